// File: rtl/formula_chain_fsm.sv
// formula_chain_fsm: evaluates res = isqrt(x0 + isqrt(x1 + ... + isqrt(x[N-1]))) using one shared isqrt unit.
// Latency: N*(L+1)+1 cycles from argument handshake to res_vld, where L is the isqrt request-to-response latency.
// Backpressure: arg_rdy only in IDLE; res_vld/res held in DONE until res_rdy; at most one isqrt request outstanding.
// Ports: clk/rst (async active-low); arg_vld/arg_rdy/args = operand set in (x[i] = args[i*W +: W]);
//        res_vld/res_rdy/res = result out; isqrt_x_vld/isqrt_x = request strobe to isqrt;
//        isqrt_y_vld/isqrt_y = isqrt response (W/2 bits).
module formula_chain_fsm #(
  parameter int N   = 3,
  parameter int W   = 32,
  parameter int SAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arg_vld,
  output logic           arg_rdy,
  input  logic [N*W-1:0] args,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [W-1:0]   res,
  output logic           isqrt_x_vld,
  output logic [W-1:0]   isqrt_x,
  input  logic           isqrt_y_vld,
  input  logic [W/2-1:0] isqrt_y
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N*W-1:0] args_q;
  logic [W-1:0]   acc;
  logic [W-1:0]   res_q;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_m1;
  logic [W-1:0]   x_sel;
  logic [W:0]     sum;
  logic [W-1:0]   acc_nxt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arg_vld) state_nxt = SEND;
      SEND:    state_nxt = WAIT;
      WAIT:    if (isqrt_y_vld) state_nxt = (idx == '0) ? DONE : SEND;
      DONE:    if (res_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next operand outward from the current one. Constant-index mux keeps every
  // select in range, including N=1 where idx_m1 is never used.
  assign idx_m1 = idx - 1'b1;

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == idx_m1) x_sel = args_q[i*W +: W];
    end
  end

  // One extra bit so the carry decides between wrap and clamp.
  assign sum     = {1'b0, x_sel} + {{(W/2+1){1'b0}}, isqrt_y};
  assign acc_nxt = ((SAT != 0) && sum[W]) ? '1 : sum[W-1:0];

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      args_q <= '0;
      acc    <= '0;
      idx    <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arg_vld) begin
            args_q <= args;
            acc    <= args[(N-1)*W +: W];
            idx    <= IW'(N-1);
          end
        end
        WAIT: begin
          if (isqrt_y_vld) begin
            if (idx == '0) begin
              res_q <= {{(W/2){1'b0}}, isqrt_y};
            end else begin
              acc <= acc_nxt;
              idx <= idx_m1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state only
  always_comb begin
    arg_rdy     = 1'b0;
    res_vld     = 1'b0;
    res         = '0;
    isqrt_x_vld = 1'b0;
    isqrt_x     = '0;
    case (state)
      IDLE: arg_rdy = 1'b1;
      SEND: begin
        isqrt_x_vld = 1'b1;
        isqrt_x     = acc;
      end
      DONE: begin
        res_vld = 1'b1;
        res     = res_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/formula_chain_fsm.md
Name: formula_chain_fsm

Overview:
- Evaluates the nested square-root chain res = isqrt(x[0] + isqrt(x[1] + ... + isqrt(x[N-1]))) for N operands.
- Uses one shared external isqrt unit over a valid-only request/response interface.
- Generalises the fixed three-operand formula FSM in operand count and data width.
- Adds input/output handshakes and an optional saturating adder mode.
- Sits between an argument producer and a result consumer; owns the single isqrt instance's request side.

Parameters:
- N, 3, number of operands; legal range 1..16.
- W, 32, operand/sum width; must be even; isqrt result width is W/2.
- SAT, 0, 0 = inner sums wrap modulo 2^W; 1 = inner sums clamp at 2^W-1.

Ports:
- clk  in  1  clock, all state changes on its rising edge.
- rst  in  1  reset: asynchronous and active-low; 0 forces the reset state immediately.
- arg_vld  in  1  argument set valid.
- arg_rdy  out  1  block can accept an argument set.
- args  in  N*W  packed operands; x[i] = args[i*W +: W]; x[0] is outermost, x[N-1] innermost.
- res_vld  out  1  result valid; held until accepted.
- res_rdy  in  1  consumer accepts result.
- res  out  W  result, zero-extended isqrt output.
- isqrt_x_vld  out  1  one-cycle request strobe to isqrt.
- isqrt_x  out  W  isqrt operand.
- isqrt_y_vld  in  1  isqrt response strobe.
- isqrt_y  in  W/2  isqrt result.

Behaviour:
- States: IDLE, SEND, WAIT, DONE.
  - Registers: args_q (N*W), acc (W), idx (clog2(N), min 1 bit), res_q (W).
- Reset (rst=0, async) forces:
  - state=IDLE, acc=0, idx=0, res_q=0;
  - outputs res_vld=0, res=0, isqrt_x_vld=0, isqrt_x=0, arg_rdy=1.
  - Asserting reset mid-operation abandons the computation. A pending isqrt response arriving after reset release is ignored, because the block is not in WAIT.
- IDLE:
  - arg_rdy=1.
  - On arg_vld: args_q<=args, acc<=x[N-1], idx<=N-1, go to SEND.
  - arg_rdy is 0 in every other state; arg_vld outside IDLE is ignored and args is not sampled.
- SEND:
  - isqrt_x_vld=1 and isqrt_x=acc for exactly one cycle, then go to WAIT.
  - Outside SEND, isqrt_x_vld=0 and isqrt_x=0.
- WAIT, on isqrt_y_vld:
  - If idx==0: res_q<=zero-extended isqrt_y, go to DONE.
  - Else: acc<=args_q x[idx-1] + isqrt_y, idx<=idx-1, go to SEND.
  - Addition is done in W+1 bits. SAT=0 keeps the low W bits. SAT=1 yields 2^W-1 when bit W is set.
  - Without isqrt_y_vld, stay in WAIT indefinitely (no timeout).
- DONE:
  - res_vld=1, res=res_q; res is stable while res_vld=1 and res_rdy=0.
  - On res_rdy, go to IDLE.
  - A new set is accepted no earlier than the cycle after the handshake.
- Outside DONE, res_vld=0 and res=0.
- isqrt_y_vld outside WAIT is ignored with no state change.
- Latency, arg handshake to first res_vld with isqrt latency L cycles from request to response: N*(L+1)+1 cycles.
- N=1: a single request with acc=x[0]; res=isqrt(x[0]).
- The block never issues a second isqrt request before the previous response; at most one request is outstanding.

Test Plan:
- N=3, W=32, SAT=0, isqrt model L=4: x={6,5,16} (x0=6) → requests 16, 9, 9 in order; res=3; res_vld rises 16 cycles after accept.
- SAT=0, N=3: x0=0, x1=0xFFFF_FFFF, x2=1 → second request 0x0000_0000, res=0. Same stimulus with SAT=1 → second request 0xFFFF_FFFF, third 65535, res=255.
- N=1: args=144 → exactly one isqrt request (operand 144), res=12; N=16 with all x=0 → 16 requests of 0, res=0.
- Backpressure: hold res_rdy=0 for 5 cycles after res_vld → res_vld and res stay constant, arg_rdy=0, a concurrent arg_vld with new args is not captured; res_rdy=1 → IDLE next cycle, then the new set is accepted.
- Reset: drop rst low during WAIT of the 2nd term, release → all outputs 0, arg_rdy=1; the isqrt response arriving after release is ignored; a following set x={6,5,16} still gives res=3.
- Spurious isqrt_y_vld pulses in IDLE and DONE → no state change, no res_vld, and res is unchanged.
